// File: rtl/draw_pkg.sv
// Shared types, constants and pair ordering for the layer draw arbiter.
// The collision feature is enabled by the LAYER_ARB_COLLISION_EN macro.
package draw_pkg;

    localparam int NUM_LAYERS = 4;
    localparam int NUM_PAIRS  = 6;

    typedef logic [7:0]            rgb_t;
    typedef logic [NUM_LAYERS-1:0] layer_mask_t;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } arb_state_t;

    // Bit position of pair (i,j), i<j, giving {23,13,12,03,02,01} MSB first.
    function automatic logic [2:0] pair_idx(input int i, input int j);
        int pos;
        pos = (i * (2 * NUM_LAYERS - i - 1)) / 2 + (j - i - 1);
        return 3'(pos);
    endfunction

endpackage

// File: rtl/layer_priority_enc.sv
// Fixed-priority encoder: lowest set bit of the qualified request vector wins.
module layer_priority_enc
    import draw_pkg::*;
(
    input  layer_mask_t eff,
    output logic        valid,
    output logic [1:0]  idx
);

    always_comb begin
        valid = 1'b0;
        idx   = 2'd0;
        // Scan from the top so the lowest index is written last and wins.
        for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
            if (eff[k]) begin
                valid = 1'b1;
                idx   = 2'(k);
            end
        end
    end

endmodule

// File: rtl/layer_draw_arbiter.sv
// Four-layer pixel arbiter with frame-deferred layer mask and optional
// per-frame pairwise collision reporting (macro LAYER_ARB_COLLISION_EN).
module layer_draw_arbiter
    import draw_pkg::*;
#(
    parameter rgb_t        BG_RGB     = 8'h00,
    parameter layer_mask_t RESET_MASK = 4'b1111
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 startOfFrame,
    input  logic [3:0]           drawingRequest,
    input  logic [7:0]           RGB0,
    input  logic [7:0]           RGB1,
    input  logic [7:0]           RGB2,
    input  logic [7:0]           RGB3,
    input  logic                 cfgValid,
    input  logic [3:0]           cfgMask,
    output logic                 drawingRequest_out,
    output logic [7:0]           RGBout,
    output logic [1:0]           layerSel,
    output logic [NUM_PAIRS-1:0] collisionFlags,
    output logic                 collisionValid
);

    arb_state_t  state_q, state_d;
    layer_mask_t active_mask_q, active_mask_d;
    layer_mask_t pend_mask_q, pend_mask_d;
    layer_mask_t eff;
    logic        win_vld;
    logic [1:0]  win_idx;
    rgb_t        rgb_d, rgb_q;
    logic        dro_q;
    logic [1:0]  sel_q;

    assign eff = drawingRequest & active_mask_q;

    layer_priority_enc u_enc (
        .eff   (eff),
        .valid (win_vld),
        .idx   (win_idx)
    );

    always_comb begin
        rgb_d = BG_RGB;
        if (win_vld) begin
            case (win_idx)
                2'd0:    rgb_d = RGB0;
                2'd1:    rgb_d = RGB1;
                2'd2:    rgb_d = RGB2;
                default: rgb_d = RGB3;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_q <= BG_RGB;
            dro_q <= 1'b0;
            sel_q <= 2'd0;
        end else begin
            rgb_q <= rgb_d;
            dro_q <= win_vld;
            sel_q <= win_vld ? win_idx : 2'd0;
        end
    end

    assign RGBout             = rgb_q;
    assign drawingRequest_out = dro_q;
    assign layerSel           = sel_q;

    // A same-cycle write at the frame boundary bypasses the pending stage.
    always_comb begin
        active_mask_d = active_mask_q;
        pend_mask_d   = pend_mask_q;
        if (cfgValid && startOfFrame) begin
            active_mask_d = cfgMask;
            pend_mask_d   = cfgMask;
        end else begin
            if (cfgValid)     pend_mask_d   = cfgMask;
            if (startOfFrame) active_mask_d = pend_mask_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            active_mask_q <= RESET_MASK;
            pend_mask_q   <= RESET_MASK;
        end else begin
            active_mask_q <= active_mask_d;
            pend_mask_q   <= pend_mask_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == IDLE && startOfFrame) state_d = ACTIVE;
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

`ifdef LAYER_ARB_COLLISION_EN
    logic [NUM_PAIRS-1:0] ovl;
    logic [NUM_PAIRS-1:0] acc_q, acc_d;
    logic [NUM_PAIRS-1:0] flags_q, flags_d;
    logic                 cvld_q, cvld_d;

    always_comb begin
        ovl = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            for (int j = i + 1; j < NUM_LAYERS; j++) begin
                if (eff[i] && eff[j]) ovl[pair_idx(i, j)] = 1'b1;
            end
        end
    end

    // Boundary-cycle overlaps seed the new frame rather than the closing one.
    always_comb begin
        acc_d   = acc_q;
        flags_d = flags_q;
        cvld_d  = 1'b0;
        if (state_q == ACTIVE) begin
            if (startOfFrame) begin
                flags_d = acc_q;
                cvld_d  = 1'b1;
                acc_d   = ovl;
            end else begin
                acc_d = acc_q | ovl;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q   <= '0;
            flags_q <= '0;
            cvld_q  <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            flags_q <= flags_d;
            cvld_q  <= cvld_d;
        end
    end

    assign collisionFlags = flags_q;
    assign collisionValid = cvld_q;
`else
    assign collisionFlags = '0;
    assign collisionValid = 1'b0;
`endif

endmodule

// File: tb/tb_layer_draw_arbiter.sv
// Scoreboard bench for layer_draw_arbiter; expectations follow the
// LAYER_ARB_COLLISION_EN setting of the build.
module tb_layer_draw_arbiter;

`ifdef LAYER_ARB_COLLISION_EN
    localparam bit COLL_EN = 1'b1;
`else
    localparam bit COLL_EN = 1'b0;
`endif
    localparam logic [7:0] BG = 8'h00;
    localparam logic [3:0] RST_MASK = 4'b1111;

    logic       clk = 1'b0;
    logic       reset, startOfFrame, cfgValid;
    logic [3:0] drawingRequest, cfgMask;
    logic [7:0] RGB0, RGB1, RGB2, RGB3;
    logic       drawingRequest_out, collisionValid;
    logic [7:0] RGBout;
    logic [1:0] layerSel;
    logic [5:0] collisionFlags;

    layer_draw_arbiter #(.BG_RGB(BG), .RESET_MASK(RST_MASK)) dut (
        .clk                (clk),
        .reset              (reset),
        .startOfFrame       (startOfFrame),
        .drawingRequest     (drawingRequest),
        .RGB0               (RGB0),
        .RGB1               (RGB1),
        .RGB2               (RGB2),
        .RGB3               (RGB3),
        .cfgValid           (cfgValid),
        .cfgMask            (cfgMask),
        .drawingRequest_out (drawingRequest_out),
        .RGBout             (RGBout),
        .layerSel           (layerSel),
        .collisionFlags     (collisionFlags),
        .collisionValid     (collisionValid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] rgb;
        logic       dro;
        logic [1:0] sel;
        logic [5:0] cf;
        logic       cv;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    logic [3:0] m_amask, m_pmask;
    logic       m_active;
    logic [5:0] m_acc, m_flags;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] pair_bits(input logic [3:0] e);
        logic [5:0] r;
        r = '0;
        r[0] = e[0] & e[1];
        r[1] = e[0] & e[2];
        r[2] = e[0] & e[3];
        r[3] = e[1] & e[2];
        r[4] = e[1] & e[3];
        r[5] = e[2] & e[3];
        return r;
    endfunction

    // One clock: drive at negedge, predict, then compare just after posedge.
    task automatic step(input logic rst, input logic sof, input logic [3:0] req,
                        input logic cv, input logic [3:0] cm);
        exp_t       e;
        logic [3:0] eff;
        logic [7:0] px [4];
        exp_t       got;
        @(negedge clk);
        reset = rst; startOfFrame = sof; drawingRequest = req;
        cfgValid = cv; cfgMask = cm;
        px[0] = RGB0; px[1] = RGB1; px[2] = RGB2; px[3] = RGB3;
        eff = req & m_amask;
        e.rgb = BG; e.dro = 1'b0; e.sel = 2'd0;
        if (!rst) begin
            for (int k = 0; k < 4; k++) begin
                if (eff[k] && !e.dro) begin
                    e.rgb = px[k]; e.dro = 1'b1; e.sel = 2'(k);
                end
            end
        end
        if (rst) begin
            m_flags = '0; m_acc = '0; e.cv = 1'b0;
            m_amask = RST_MASK; m_pmask = RST_MASK; m_active = 1'b0;
        end else begin
            e.cv = 1'b0;
            if (COLL_EN && m_active) begin
                if (sof) begin
                    m_flags = m_acc; e.cv = 1'b1; m_acc = pair_bits(eff);
                end else begin
                    m_acc = m_acc | pair_bits(eff);
                end
            end
            if (cv && sof) begin m_amask = cm; m_pmask = cm; end
            else begin
                if (sof) m_amask = m_pmask;
                if (cv)  m_pmask = cm;
            end
            if (sof) m_active = 1'b1;
        end
        e.cf = m_flags;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        got = {RGBout, drawingRequest_out, layerSel, collisionFlags, collisionValid};
        chk("RGBout", 32'(got.rgb), 32'(e.rgb));
        chk("drawingRequest_out", 32'(got.dro), 32'(e.dro));
        chk("layerSel", 32'(got.sel), 32'(e.sel));
        chk("collisionFlags", 32'(got.cf), 32'(e.cf));
        chk("collisionValid", 32'(got.cv), 32'(e.cv));
    endtask

    initial begin
        reset = 1'b1; startOfFrame = 1'b0; cfgValid = 1'b0; cfgMask = 4'h0;
        drawingRequest = 4'h0;
        RGB0 = 8'h11; RGB1 = 8'h1C; RGB2 = 8'h33; RGB3 = 8'hE0;
        m_amask = RST_MASK; m_pmask = RST_MASK; m_active = 1'b0;
        m_acc = '0; m_flags = '0;

        step(1, 0, 4'h0, 0, 4'h0);
        step(1, 1, 4'hF, 1, 4'h0);
        chk("reset_rgb", 32'(RGBout), 32'(BG));
        chk("reset_sel", 32'(layerSel), 32'd0);

        // Priority: layer 1 beats layer 3 even while IDLE.
        step(0, 0, 4'b1010, 0, 4'h0);
        chk("prio_rgb", 32'(RGBout), 32'h1C);
        chk("prio_sel", 32'(layerSel), 32'd1);
        step(0, 0, 4'b1000, 0, 4'h0);
        step(0, 0, 4'b0101, 0, 4'h0);
        step(0, 1, 4'b0000, 0, 4'h0);
        chk("idle_sof_cv", 32'(collisionValid), 32'd0);

        // Pair 02 overlap then frame boundary.
        step(0, 0, 4'b0101, 0, 4'h0);
        step(0, 1, 4'b0000, 0, 4'h0);
        chk("pair02_flags", 32'(collisionFlags), COLL_EN ? 32'b000010 : 32'd0);
        chk("pair02_cv", 32'(collisionValid), 32'(COLL_EN));
        step(0, 0, 4'b0000, 0, 4'h0);
        chk("cv_one_cycle", 32'(collisionValid), 32'd0);

        // Boundary overlap goes to the new frame.
        step(0, 0, 4'b1100, 0, 4'h0);
        step(0, 1, 4'b0011, 0, 4'h0);
        chk("bnd_flags", 32'(collisionFlags), COLL_EN ? 32'b100000 : 32'd0);
        step(0, 0, 4'b0000, 0, 4'h0);
        step(0, 1, 4'b0000, 0, 4'h0);
        chk("bnd_next_flags", 32'(collisionFlags), COLL_EN ? 32'b000001 : 32'd0);

        // Mask write mid-frame is deferred to the next boundary.
        step(0, 0, 4'b0010, 1, 4'b1101);
        chk("defer_rgb", 32'(RGBout), 32'h1C);
        step(0, 0, 4'b0010, 0, 4'h0);
        step(0, 1, 4'b0010, 0, 4'h0);
        chk("defer_sof_rgb", 32'(RGBout), 32'h1C);
        step(0, 0, 4'b0010, 0, 4'h0);
        chk("masked_rgb", 32'(RGBout), 32'(BG));
        chk("masked_dro", 32'(drawingRequest_out), 32'd0);
        // Masked layer 1 contributes no pair 01.
        step(0, 0, 4'b0011, 0, 4'h0);
        step(0, 1, 4'b0000, 1, 4'b1111);
        chk("masked_coll", 32'(collisionFlags), 32'd0);
        step(0, 0, 4'b0010, 0, 4'h0);
        chk("bypass_rgb", 32'(RGBout), 32'h1C);

        // Reset mid-frame discards the accumulated overlap.
        step(0, 0, 4'b0110, 0, 4'h0);
        step(1, 0, 4'b0000, 0, 4'h0);
        step(0, 1, 4'b0000, 0, 4'h0);
        chk("rst_first_sof_cv", 32'(collisionValid), 32'd0);
        step(0, 0, 4'b0000, 0, 4'h0);
        step(0, 1, 4'b0000, 0, 4'h0);
        chk("rst_second_flags", 32'(collisionFlags), 32'd0);
        chk("rst_second_cv", 32'(collisionValid), 32'(COLL_EN));

        // Randomised traffic against the model.
        for (int n = 0; n < 300; n++) begin
            RGB0 = 8'($urandom); RGB1 = 8'($urandom);
            RGB2 = 8'($urandom); RGB3 = 8'($urandom);
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) == 0),
                 4'($urandom), ($urandom_range(0, 7) == 0), 4'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/layer_draw_arbiter.md
LAYER_DRAW_ARBITER -- requirements
Module: layer_draw_arbiter

Interface
REQ-001 SHALL have parameter BG_RGB, default 8'h00, the colour output when no enabled layer requests.
REQ-002 SHALL have parameter RESET_MASK, default 4'b1111, the layer-enable mask loaded at reset.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have port startOfFrame, input, 1, a one-cycle pulse marking the frame boundary.
REQ-006 SHALL have port drawingRequest, input, 4, the per-layer draw request; bit 0 is the highest priority.
REQ-007 SHALL have ports RGB0..RGB3, input, 8 each, the per-layer pixel colour.
REQ-008 SHALL have port cfgValid, input, 1, a write strobe for the layer mask.
REQ-009 SHALL have port cfgMask, input, 4, the new layer-enable mask.
REQ-010 SHALL have port drawingRequest_out, output, 1; high when any enabled layer requests.
REQ-011 SHALL have port RGBout, output, 8, the arbitrated pixel colour.
REQ-012 SHALL have port layerSel, output, 2, the index of the winning layer; 0 when none wins.
REQ-013 SHALL have port collisionFlags, output, 6, the per-pair overlap flags of the last frame; bit order {23,13,12,03,02,01}, MSB first.
REQ-014 SHALL have port collisionValid, output, 1, a one-cycle pulse when collisionFlags updates.

Function
REQ-015 SHALL qualify requests per cycle: eff = drawingRequest & activeMask.
REQ-016 SHALL pick the winner as the lowest-index set bit of eff (fixed priority, 0 highest).
REQ-017 SHALL register RGBout, drawingRequest_out and layerSel with exactly 1 cycle latency from the inputs.
REQ-018 SHALL drive RGBout=BG_RGB, drawingRequest_out=0 and layerSel=0 when eff==0.
REQ-019 SHALL implement FSM states IDLE and ACTIVE.
- IDLE is entered at reset.
- IDLE goes to ACTIVE on the first startOfFrame.
- ACTIVE has no exit except reset.
REQ-020 SHALL, in IDLE, still arbitrate pixels but not accumulate collisions and not assert collisionValid.
REQ-021 SHALL latch cfgMask into pendingMask on cfgValid; a later cfgValid overwrites an earlier one.
REQ-022 SHALL copy pendingMask to activeMask on startOfFrame only, so the mask never changes mid-frame.
REQ-023 SHALL, when cfgValid and startOfFrame occur in the same cycle, load cfgMask directly into both activeMask and pendingMask.
REQ-024 SHALL, in ACTIVE, OR accumulate pairwise overlaps (eff[i]&eff[j]) each cycle into a sticky 6-bit accumulator.
REQ-025 SHALL, on startOfFrame in ACTIVE:
- copy the accumulator into collisionFlags;
- pulse collisionValid for 1 cycle;
- load the accumulator with the current cycle's overlaps, so an overlap in the boundary cycle belongs to the new frame.
REQ-026 SHALL hold collisionFlags constant between updates.
REQ-027 SHALL NOT count masked-off layers toward collisions.

Reset
REQ-028 SHALL, on reset high at a clk edge, set:
- RGBout=BG_RGB, drawingRequest_out=0, layerSel=0;
- collisionFlags=0, collisionValid=0, accumulator=0;
- activeMask=pendingMask=RESET_MASK;
- FSM=IDLE.
REQ-029 SHALL let reset take precedence over startOfFrame and cfgValid in the same cycle; reset mid-frame discards accumulated collisions.

Configuration
REQ-030 SHALL compile collision tracking in when LAYER_ARB_COLLISION_EN is defined, implementing REQ-024..REQ-027.
REQ-031 SHALL, without LAYER_ARB_COLLISION_EN, tie collisionFlags=0 and collisionValid=0, instantiate no accumulator, and leave the FSM and arbitration unchanged.

Structure
REQ-032 SHALL place the following in shared package draw_pkg:
- constants NUM_LAYERS=4 and NUM_PAIRS=6;
- typedef rgb_t (8-bit);
- typedef layer_mask_t (4-bit);
- typedef arb_state_t {IDLE, ACTIVE};
- the pair-index ordering function.
REQ-033 SHALL isolate the combinational fixed-priority encoder (eff -> valid, index) in sub-module layer_priority_enc.

Verification
REQ-034 Bench SHALL cover priority:
- stimulus: drawingRequest=4'b1010, RGB1=8'h1C, RGB3=8'hE0, mask 1111;
- response: next cycle RGBout=8'h1C, layerSel=1, drawingRequest_out=1.
REQ-035 Bench SHALL cover masking and deferral:
- stimulus: cfgValid with cfgMask=4'b1101 mid-frame, drawingRequest=4'b0010;
- response: RGBout=RGB1 until the next startOfFrame, then RGBout=BG_RGB and drawingRequest_out=0.
REQ-036 Bench SHALL cover collision reporting:
- stimulus: in ACTIVE, drawingRequest=4'b0101 for 1 cycle, then startOfFrame;
- response: collisionValid pulses 1 cycle with collisionFlags=6'b000010 (pair 02).
REQ-037 Bench SHALL cover the boundary overlap:
- stimulus: drawingRequest=4'b0011 in the same cycle as startOfFrame;
- response: flags reported at that boundary exclude pair 01; the next report includes it (6'b000001).
REQ-038 Bench SHALL cover reset mid-frame:
- stimulus: overlap, then reset, then two startOfFrame pulses;
- response: no collisionValid at the first pulse (IDLE->ACTIVE); flags=0 at the second.
REQ-039 Bench SHALL cover the macro-off build:
- stimulus: any overlapping requests;
- response: collisionFlags=0 and collisionValid=0 always.
